// File: rtl/jtag_axi_tap_ctrl.sv
// IEEE 1149.1 TAP controller and instruction register for the JTAG-to-AXI bridge.
// The block runs the 16-state TAP FSM, shifts and latches the IR, decodes the
// opcode for the data-register block, and drives the TDO pin.
// Optional build macro JTAG_TDO_OE_EN adds a negedge-registered tdo_oe output
// and forces tdo low whenever the pin is not being driven.
//
// state            | meaning
// TEST_LOGIC_RESET | test logic reset, IR latch forced to IDCODE
// RUN_TEST_IDLE    | idle between scans
// SELECT_DR_SCAN   | choose DR scan, or go on to the IR column
// CAPTURE_DR       | DR block captures its parallel value
// SHIFT_DR         | DR block shifts, tdo follows tdo_dr_i
// EXIT1_DR         | leave shift, last DR bit still on tdo
// PAUSE_DR         | DR shift halted
// EXIT2_DR         | resume DR shift or update
// UPDATE_DR        | DR block latches its shifted value
// SELECT_IR_SCAN   | choose IR scan, or return to reset
// CAPTURE_IR       | ir_sr loads the 2'b01 capture pattern
// SHIFT_IR         | ir_sr shifts LSB first, tdo follows ir_n_q
// EXIT1_IR         | leave shift, last IR bit still on tdo
// PAUSE_IR         | IR shift halted, ir_sr held
// EXIT2_IR         | resume IR shift or update
// UPDATE_IR        | ir_ff latches ir_sr

package jtag_axi_tap_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR_SCAN, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_ctrl_fsm_t;

  typedef enum logic [3:0] {
    EXTEST, SAMPLE_PRELOAD, IC_RESET, IDCODE,
    ADDR_AXI_REG, DATA_W_AXI_REG, CTRL_AXI_REG, STATUS_AXI_REG,
    BYPASS
  } ir_decoding_t;
endpackage

module jtag_axi_tap_ctrl
  import jtag_axi_tap_pkg::*;
#(
  parameter int IR_WIDTH = 4
) (
  input  logic          tck,
  input  logic          trst,
  input  logic          tms,
  input  logic          tdi,
  input  logic          tdo_dr_i,
  output logic          tdo,
  output tap_ctrl_fsm_t tap_state,
  output ir_decoding_t  ir_dec
`ifdef JTAG_TDO_OE_EN
  ,
  output logic          tdo_oe
`endif
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE   = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_ALL_ONES = '1;

  tap_ctrl_fsm_t       state_q;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic [IR_WIDTH-1:0] ir_ff_q;
  logic [IR_WIDTH-1:0] ir_ff_d;
  ir_decoding_t        ir_dec_q;
  logic                ir_n_q;
  logic                ir_path;
  logic                tdo_mux;

  // Opcodes above 7 (any bit from bit 3 up) and all-ones select BYPASS.
  function automatic ir_decoding_t decode_ir(input logic [IR_WIDTH-1:0] op);
    logic [IR_WIDTH+3:0] op_ext;
    op_ext = {4'b0000, op};
    if (op == IR_ALL_ONES || op_ext[IR_WIDTH+3:3] != '0) return BYPASS;
    return ir_decoding_t'(op_ext[3:0]);
  endfunction

  // TAP state transitions on tms
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      case (state_q)
        TEST_LOGIC_RESET: state_q <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_q <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_DR_SCAN:   state_q <= tms ? SELECT_IR_SCAN   : CAPTURE_DR;
        CAPTURE_DR:       state_q <= tms ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state_q <= tms ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state_q <= tms ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state_q <= tms ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state_q <= tms ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state_q <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_IR_SCAN:   state_q <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_q <= tms ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state_q <= tms ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state_q <= tms ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state_q <= tms ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state_q <= tms ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state_q <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        default:          state_q <= TEST_LOGIC_RESET;
      endcase
    end
  end

  // IR shift register: capture pattern, then shift LSB first
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr_q <= '0;
    end else if (state_q == CAPTURE_IR) begin
      ir_sr_q <= IR_CAPTURE;
    end else if (state_q == SHIFT_IR) begin
      ir_sr_q <= {tdi, ir_sr_q[IR_WIDTH-1:1]};
    end
  end

  // Next IR latch value; TEST_LOGIC_RESET wins over everything else
  always_comb begin
    ir_ff_d = ir_ff_q;
    if (state_q == TEST_LOGIC_RESET) ir_ff_d = IR_IDCODE;
    else if (state_q == UPDATE_IR)   ir_ff_d = ir_sr_q;
  end

  // IR latch and decode register; decoding the next latch value lets ir_dec
  // become valid in the cycle right after UPDATE_IR / TEST_LOGIC_RESET
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_ff_q  <= IR_IDCODE;
      ir_dec_q <= IDCODE;
    end else begin
      ir_ff_q  <= ir_ff_d;
      ir_dec_q <= decode_ir(ir_ff_d);
    end
  end

  // Negedge copy of the IR serial output so tdo changes on the falling edge
  always_ff @(negedge tck or posedge trst) begin
    if (trst) ir_n_q <= 1'b0;
    else      ir_n_q <= ir_sr_q[0];
  end

  assign ir_path   = (state_q == SHIFT_IR) || (state_q == EXIT1_IR);
  assign tdo_mux   = ir_path ? ir_n_q : tdo_dr_i;
  assign tap_state = state_q;
  assign ir_dec    = ir_dec_q;

`ifdef JTAG_TDO_OE_EN
  logic tdo_oe_q;

  // Output enable follows the shift/exit1 states, aligned to the falling edge
  always_ff @(negedge tck or posedge trst) begin
    if (trst) tdo_oe_q <= 1'b0;
    else      tdo_oe_q <= ir_path || (state_q == SHIFT_DR) || (state_q == EXIT1_DR);
  end

  assign tdo_oe = tdo_oe_q;
  assign tdo    = tdo_oe_q & tdo_mux;
`else
  assign tdo    = tdo_mux;
`endif

endmodule

// File: tb/tb_jtag_axi_tap_ctrl.sv
// Randomized bench for jtag_axi_tap_ctrl against a table-driven TAP model.
// Build with JTAG_TDO_OE_EN defined to also cover the tdo_oe variant.
module tb_jtag_axi_tap_ctrl;
  import jtag_axi_tap_pkg::*;

  localparam int W = 4;

  logic          tck = 1'b0;
  logic          trst;
  logic          tms;
  logic          tdi;
  logic          tdo_dr_i;
  logic          tdo;
  tap_ctrl_fsm_t tap_state;
  ir_decoding_t  ir_dec;
`ifdef JTAG_TDO_OE_EN
  logic          tdo_oe;
`endif

  jtag_axi_tap_ctrl #(.IR_WIDTH(W)) dut (
    .tck      (tck),
    .trst     (trst),
    .tms      (tms),
    .tdi      (tdi),
    .tdo_dr_i (tdo_dr_i),
    .tdo      (tdo),
    .tap_state(tap_state),
    .ir_dec   (ir_dec)
`ifdef JTAG_TDO_OE_EN
    ,
    .tdo_oe   (tdo_oe)
`endif
  );

  always #5 tck = ~tck;

  int            n_chk = 0;
  int            n_bad = 0;
  tap_ctrl_fsm_t nxt [16][2];
  tap_ctrl_fsm_t m_state;
  int            m_sr;
  int            m_ff;
  logic          last_tdo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ir_decoding_t exp_dec(input int op);
    if (op > 7 || op == (1 << W) - 1) return BYPASS;
    return ir_decoding_t'(4'(op));
  endfunction

  task automatic model_reset();
    m_state = TEST_LOGIC_RESET;
    m_sr    = 0;
    m_ff    = 3;
  endtask

  task automatic check_outputs();
    logic ir_path;
    logic exp_tdo;
    chk("state", 32'(tap_state), 32'(m_state));
    chk("ir_dec", 32'(ir_dec), 32'(exp_dec(m_ff)));
    ir_path = (m_state == SHIFT_IR) || (m_state == EXIT1_IR);
    exp_tdo = ir_path ? m_sr[0] : tdo_dr_i;
`ifdef JTAG_TDO_OE_EN
    begin
      logic oe;
      oe = ir_path || (m_state == SHIFT_DR) || (m_state == EXIT1_DR);
      chk("tdo_oe", 32'(tdo_oe), 32'(oe));
      if (!oe) exp_tdo = 1'b0;
    end
`endif
    chk("tdo", 32'(tdo), 32'(exp_tdo));
  endtask

  // One tck cycle: drive, check before the rising edge, advance the model
  task automatic step(input logic t_ms, input logic t_di, input logic dr);
    int sr_n;
    tms = t_ms;
    tdi = t_di;
    tdo_dr_i = dr;
    #1;
    check_outputs();
    last_tdo = tdo;
    @(posedge tck);
    if (m_state == CAPTURE_IR)    sr_n = 1;
    else if (m_state == SHIFT_IR) sr_n = (m_sr >> 1) | (int'(t_di) << (W - 1));
    else                          sr_n = m_sr;
    if (m_state == TEST_LOGIC_RESET) m_ff = 3;
    else if (m_state == UPDATE_IR)   m_ff = m_sr;
    m_sr    = sr_n;
    m_state = nxt[int'(m_state)][int'(t_ms)];
    @(negedge tck);
    #1;
  endtask

  task automatic pulse_trst();
    trst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    trst = 1'b0;
    #1;
  endtask

  // From RUN_TEST_IDLE: scan an opcode into the IR and return to RUN_TEST_IDLE
  task automatic load_ir(input int op, input ir_decoding_t want);
    logic [W-1:0] obs;
    logic [W-1:0] opv;
    opv = W'(op);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < W; i++) begin
      step(i == W - 1, opv[i], 1'($urandom_range(1)));
      obs[i] = last_tdo;
    end
    step(1, 0, 0);
    step(0, 0, 0);
    chk("ir_capture_out", 32'(obs), 32'(1));
    chk("ir_load_dec", 32'(ir_dec), 32'(want));
    chk("ir_load_rti", 32'(tap_state), 32'(RUN_TEST_IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tap_ctrl_fsm_t walk [5];

    nxt[int'(TEST_LOGIC_RESET)] = '{RUN_TEST_IDLE,  TEST_LOGIC_RESET};
    nxt[int'(RUN_TEST_IDLE)]    = '{RUN_TEST_IDLE,  SELECT_DR_SCAN};
    nxt[int'(SELECT_DR_SCAN)]   = '{CAPTURE_DR,     SELECT_IR_SCAN};
    nxt[int'(CAPTURE_DR)]       = '{SHIFT_DR,       EXIT1_DR};
    nxt[int'(SHIFT_DR)]         = '{SHIFT_DR,       EXIT1_DR};
    nxt[int'(EXIT1_DR)]         = '{PAUSE_DR,       UPDATE_DR};
    nxt[int'(PAUSE_DR)]         = '{PAUSE_DR,       EXIT2_DR};
    nxt[int'(EXIT2_DR)]         = '{SHIFT_DR,       UPDATE_DR};
    nxt[int'(UPDATE_DR)]        = '{RUN_TEST_IDLE,  SELECT_DR_SCAN};
    nxt[int'(SELECT_IR_SCAN)]   = '{CAPTURE_IR,     TEST_LOGIC_RESET};
    nxt[int'(CAPTURE_IR)]       = '{SHIFT_IR,       EXIT1_IR};
    nxt[int'(SHIFT_IR)]         = '{SHIFT_IR,       EXIT1_IR};
    nxt[int'(EXIT1_IR)]         = '{PAUSE_IR,       UPDATE_IR};
    nxt[int'(PAUSE_IR)]         = '{PAUSE_IR,       EXIT2_IR};
    nxt[int'(EXIT2_IR)]         = '{SHIFT_IR,       UPDATE_IR};
    nxt[int'(UPDATE_IR)]        = '{RUN_TEST_IDLE,  SELECT_DR_SCAN};

    // reset state
    trst = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    tdo_dr_i = 1'b1;
    model_reset();
    @(negedge tck);
    #1;
    check_outputs();
    chk("rst_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
    chk("rst_dec", 32'(ir_dec), 32'(IDCODE));
    trst = 1'b0;
    #1;

    // FSM walk into SHIFT_IR
    walk = '{RUN_TEST_IDLE, SELECT_DR_SCAN, SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR};
    step(0, 0, 0); chk("walk0", 32'(tap_state), 32'(walk[0]));
    step(1, 0, 0); chk("walk1", 32'(tap_state), 32'(walk[1]));
    step(1, 0, 0); chk("walk2", 32'(tap_state), 32'(walk[2]));
    step(0, 0, 0); chk("walk3", 32'(tap_state), 32'(walk[3]));
    step(0, 0, 0); chk("walk4", 32'(tap_state), 32'(walk[4]));

    // trst mid-shift discards the partial IR
    step(0, 1, 0);
    step(0, 0, 1);
    pulse_trst();
    step(0, 1, 0);
    chk("trst_rti", 32'(tap_state), 32'(RUN_TEST_IDLE));
    chk("trst_dec", 32'(ir_dec), 32'(IDCODE));

    // opcode loads, including unused and all-ones
    load_ir(6, CTRL_AXI_REG);
    load_ir(10, BYPASS);
    load_ir(15, BYPASS);

    // five tms=1 from SHIFT_DR reach TEST_LOGIC_RESET
    load_ir(5, DATA_W_AXI_REG);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("sdr_state", 32'(tap_state), 32'(SHIFT_DR));
    chk("sdr_dec", 32'(ir_dec), 32'(DATA_W_AXI_REG));
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("tms_rst_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
    step(1, 0, 0);
    chk("tms_rst_dec", 32'(ir_dec), 32'(IDCODE));

    // TDO muxing in PAUSE_IR and SHIFT_DR
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    chk("pause_state", 32'(tap_state), 32'(PAUSE_IR));
`ifdef JTAG_TDO_OE_EN
    chk("pause_oe", 32'(tdo_oe), 32'(0));
    chk("pause_tdo", 32'(tdo), 32'(0));
`else
    chk("pause_tdo", 32'(tdo), 32'(1));
`endif
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("sdr2_state", 32'(tap_state), 32'(SHIFT_DR));
`ifdef JTAG_TDO_OE_EN
    chk("sdr_oe", 32'(tdo_oe), 32'(1));
`endif
    chk("sdr_tdo_hi", 32'(tdo), 32'(1));
    tdo_dr_i = 1'b0;
    #1;
    chk("sdr_tdo_lo", 32'(tdo), 32'(0));

    // random walk with occasional async resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(63) == 0) pulse_trst();
      else step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
